vermi_branch_vic: RTL
=====================

Name: vermi_branch_vic

Overview:
- Next-PC unit with a vectored interrupt controller. It selects the next program counter from the sequential PC, jump/branch target, MRET return, trap vector or one of N prioritised IRQ vectors.
- Adds per-line edge-latched pending bits, a mask, fixed priority and vector selection.
- Saves the return address (mepc) and the cause (mcause).
- Sits in the execute stage between the ALU address output and the fetch PC register.

Parameters:
- N_IRQ, 4, number of interrupt lines (1..16).
- IRQ_BASE, 32'h0000_0100, interrupt vector base (word aligned).
- TRAP_ADDRESS, 32'h0000_0080, trap handler address.
- VECTORED, 1, 1: vector = IRQ_BASE + 4*id; 0: all IRQs go to IRQ_BASE.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  pipeline advance; architectural state updates only when high
- irq  in  N_IRQ  interrupt request lines, rising-edge sensitive
- irq_mask  in  N_IRQ  1 = line enabled
- instr  in  instruction_t  decoded instruction (is_jump, is_branch, is_mret, is_trap, ...)
- xs1, xs2  in  word_t  branch comparison operands
- address  in  word_t  computed jump/branch target
- pc_incr  in  word_t  sequential PC
- pc_next  out  word_t  next PC (combinational)
- mepc  out  word_t  saved return PC
- mcause  out  word_t  bit31 = interrupt, [3:0] = id; traps give 32'h0000_000B
- in_irq  out  1  interrupt-handler state
- irq_ack  out  1  one-cycle pulse on acceptance
- irq_ack_id  out  $clog2(N_IRQ) (min 1)  accepted line id, valid with irq_ack

Behaviour:
- Reset (clk edge with reset=1): pending_reg=0, irq_prev_reg=0, in_irq=0, mepc=0, mcause=0, irq_ack=0.
- taken: computed by the existing branch comparator from instr, xs1, xs2.
- pc_target priority: is_mret -> mepc; is_jump or (is_branch and taken) -> {address[31:2],2'b0}; else pc_incr.
- Edge detection: irq_prev_reg <= irq every cycle, independent of enable. rise = irq & ~irq_prev_reg.
- Pending update, every cycle: pending_reg <= (pending_reg & ~clr) | rise.
  - clr is the one-hot of the accepted id, only in a cycle with an accept.
  - A new rise on the accepted line in the same cycle leaves that bit set.
- Candidates: cand = pending_reg & irq_mask. Selected id = lowest-index set bit of cand.
- accept = enable & ~in_irq & |cand.
  - Masked lines stay pending and are taken as soon as they are unmasked.
- pc_next priority:
  - accept -> VECTORED ? IRQ_BASE + 4*id : IRQ_BASE
  - else is_trap -> TRAP_ADDRESS
  - else pc_target
  - pc_next is evaluated even when enable=0.
- On accept: mepc <= pc_target; mcause <= {1'b1, 27'b0, id}; in_irq <= 1; irq_ack <= 1 and irq_ack_id <= id on the next clock (registered pulse, one cycle).
- On is_trap without accept: mepc <= pc_target; mcause <= 32'h0000_000B; in_irq is unchanged.
- On is_mret with enable: in_irq <= 0.
  - If in_irq is already 0 and an accept fires in the same cycle, the accept wins: in_irq=1 and mepc <= old mepc (chained return).
- Nesting: none. While in_irq=1, new rises only accumulate in pending_reg.
- enable=0: mepc, mcause, in_irq, irq_ack (forced 0) and pending clears are frozen. Edges are still captured.
- Reset asserted mid-handler: all state returns to its reset value; pending IRQs are lost.

Decomposition:
- Vermitypes_pkg: add irq_vec_t (logic [N_IRQ-1:0]) and a cause_t encoding.
- Vermicodes_pkg: add CAUSE_ECALL = 32'h0000_000B and CAUSE_IRQ_FLAG = 32'h8000_0000.
- Sub-module vermi_irq_arbiter: holds the pending register, edge detection and the fixed-priority encoder. Outputs any, id and the clr one-hot.

Test Plan:
- Reset, then irq=4'b0010 rising with mask=4'hF, enable=1, pc_incr=0x204 -> pc_next=0x104, mepc=0x204, mcause=0x8000_0001, irq_ack pulse with id=1, in_irq=1.
- Rises on lines 3 and 1 in the same cycle -> id 1 taken first. After MRET (pc_next=0x204, in_irq=0) -> line 3 taken: pc_next=0x10C, mcause=0x8000_0003.
- irq[2] rises with mask[2]=0 -> no accept, pc_next=pc_incr. Set mask[2]=1 later -> accept id 2, pc_next=0x108.
- Second rise of irq[0] while in_irq=1 -> no redirect. After MRET, the next cycle accepts id 0 at 0x100.
- is_trap with pc_incr=0x40 and no IRQ -> pc_next=0x80, mepc=0x40, mcause=0xB, in_irq=0. Same cycle plus irq[0] rise -> IRQ wins, pc_next=0x100.
- enable=0 during an irq[1] rise -> no state change, pending kept. enable=1 -> accepted. Reset asserted while in_irq=1 -> in_irq=0, mepc=0, pending cleared.

Source files
------------

// File: rtl/vermi_branch_vic_pkg.sv
// Shared types and cause codes for the next-PC unit and its interrupt arbiter.
// No logic; widths here are upper bounds, per-instance widths come from parameters.
package vermi_branch_vic_pkg;

    typedef logic [31:0] word_t;

    localparam int IRQ_MAX = 16;
    typedef logic [IRQ_MAX-1:0] irq_vec_t;

    typedef enum logic [2:0] {
        BR_EQ  = 3'd0,
        BR_NE  = 3'd1,
        BR_LT  = 3'd4,
        BR_GE  = 3'd5,
        BR_LTU = 3'd6,
        BR_GEU = 3'd7
    } br_op_t;

    typedef struct packed {
        logic   is_jump;
        logic   is_branch;
        logic   is_mret;
        logic   is_trap;
        br_op_t br_op;
    } instruction_t;

    typedef struct packed {
        logic        irq;
        logic [26:0] rsvd;
        logic [3:0]  code;
    } cause_t;

    localparam word_t CAUSE_ECALL    = 32'h0000_000B;
    localparam word_t CAUSE_IRQ_FLAG = 32'h8000_0000;

    function automatic cause_t irq_cause(input logic [3:0] id);
        return cause_t'(CAUSE_IRQ_FLAG | {28'b0, id});
    endfunction

endpackage

// File: rtl/vermi_irq_arbiter.sv
// Rising-edge IRQ latch with mask and lowest-index-first priority selection.
// Latency: an edge becomes a candidate the cycle after it is seen.
// Backpressure: pending bits are held until the owner asserts take.
module vermi_irq_arbiter #(
    parameter int N_IRQ = 4,
    parameter int IDW   = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq,
    input  logic [N_IRQ-1:0] irq_mask,
    input  logic             take,
    output logic             any,
    output logic [IDW-1:0]   id,
    output logic [N_IRQ-1:0] clr
);

    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] irq_prev_q, irq_prev_d;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] cand;

    always_comb begin
        rise = irq & ~irq_prev_q;
        cand = pending_q & irq_mask;
        any  = |cand;
        id   = '0;
        // Scan downwards so the lowest set index is the last one written.
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                id = IDW'(i);
            end
        end
        clr = '0;
        if (take && any) begin
            clr[id] = 1'b1;
        end
        // A fresh edge on the line being cleared keeps it pending.
        pending_d  = (pending_q & ~clr) | rise;
        irq_prev_d = irq;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q  <= '0;
            irq_prev_q <= '0;
        end else begin
            pending_q  <= pending_d;
            irq_prev_q <= irq_prev_d;
        end
    end

endmodule

// File: rtl/vermi_branch_vic.sv
// Next-PC select (sequential, jump/branch, MRET, trap, vectored IRQ) with mepc/mcause.
// Latency: pc_next is combinational; mepc/mcause/in_irq/irq_ack update on the next clock.
// Backpressure: enable=0 freezes architectural state while edges are still latched.
module vermi_branch_vic
    import vermi_branch_vic_pkg::*;
#(
    parameter int    N_IRQ        = 4,
    parameter word_t IRQ_BASE     = 32'h0000_0100,
    parameter word_t TRAP_ADDRESS = 32'h0000_0080,
    parameter bit    VECTORED     = 1'b1,
    localparam int   IDW          = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [N_IRQ-1:0] irq,
    input  logic [N_IRQ-1:0] irq_mask,
    input  instruction_t     instr,
    input  word_t            xs1,
    input  word_t            xs2,
    input  word_t            address,
    input  word_t            pc_incr,
    output word_t            pc_next,
    output word_t            mepc,
    output word_t            mcause,
    output logic             in_irq,
    output logic             irq_ack,
    output logic [IDW-1:0]   irq_ack_id
);

    logic             taken;
    word_t            pc_target;
    logic             take;
    logic             accept;
    logic             any;
    logic [IDW-1:0]   id;
    logic [N_IRQ-1:0] clr;

    word_t          mepc_q, mepc_d;
    cause_t         mcause_q, mcause_d;
    logic           in_irq_q, in_irq_d;
    logic           irq_ack_q, irq_ack_d;
    logic [IDW-1:0] irq_ack_id_q, irq_ack_id_d;

    assign take   = enable & ~in_irq_q;
    assign accept = |clr;

    vermi_irq_arbiter #(
        .N_IRQ (N_IRQ),
        .IDW   (IDW)
    ) u_arbiter (
        .clk      (clk),
        .reset    (reset),
        .irq      (irq),
        .irq_mask (irq_mask),
        .take     (take),
        .any      (any),
        .id       (id),
        .clr      (clr)
    );

    always_comb begin
        case (instr.br_op)
            BR_EQ:   taken = (xs1 == xs2);
            BR_NE:   taken = (xs1 != xs2);
            BR_LT:   taken = ($signed(xs1) < $signed(xs2));
            BR_GE:   taken = ($signed(xs1) >= $signed(xs2));
            BR_LTU:  taken = (xs1 < xs2);
            BR_GEU:  taken = (xs1 >= xs2);
            default: taken = 1'b0;
        endcase

        if (instr.is_mret) begin
            pc_target = mepc_q;
        end else if (instr.is_jump || (instr.is_branch && taken)) begin
            pc_target = address & 32'hFFFF_FFFC;
        end else begin
            pc_target = pc_incr;
        end

        if (accept) begin
            pc_next = VECTORED ? (IRQ_BASE + (word_t'(id) << 2)) : IRQ_BASE;
        end else if (instr.is_trap) begin
            pc_next = TRAP_ADDRESS;
        end else begin
            pc_next = pc_target;
        end
    end

    always_comb begin
        mepc_d       = mepc_q;
        mcause_d     = mcause_q;
        in_irq_d     = in_irq_q;
        irq_ack_d    = accept;
        irq_ack_id_d = irq_ack_id_q;
        if (accept) begin
            // MRET+accept with in_irq low: pc_target is old mepc, so it is preserved.
            mepc_d       = pc_target;
            mcause_d     = irq_cause(4'(id));
            in_irq_d     = 1'b1;
            irq_ack_id_d = id;
        end else if (enable) begin
            if (instr.is_trap) begin
                mepc_d   = pc_target;
                mcause_d = cause_t'(CAUSE_ECALL);
            end
            if (instr.is_mret) begin
                in_irq_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mepc_q       <= '0;
            mcause_q     <= '0;
            in_irq_q     <= 1'b0;
            irq_ack_q    <= 1'b0;
            irq_ack_id_q <= '0;
        end else begin
            mepc_q       <= mepc_d;
            mcause_q     <= mcause_d;
            in_irq_q     <= in_irq_d;
            irq_ack_q    <= irq_ack_d;
            irq_ack_id_q <= irq_ack_id_d;
        end
    end

    assign mepc       = mepc_q;
    assign mcause     = mcause_q;
    assign in_irq     = in_irq_q;
    assign irq_ack    = irq_ack_q;
    assign irq_ack_id = irq_ack_id_q;

endmodule
